// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle FP32 adder/subtractor built around one 24-bit
// carry-lookahead mantissa adder. Operands are unpacked on accept, the
// smaller mantissa is aligned ALIGN_STEP bits per cycle, added in one cycle,
// then normalised one bit per cycle and packed. Rounding is truncation and
// denormal inputs are treated as zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, sub            IEEE-754 single operands; sub=1 computes a-b
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   result, flags        packed result and {invalid, overflow, underflow}

// CLA24bit: 24-bit adder built from six 4-bit lookahead blocks.
// Ports: A, B operands; Ci carry in; S sum; Co carry out.
module CLA24bit (
  input  logic [23:0] A,
  input  logic [23:0] B,
  input  logic        Ci,
  output logic [23:0] S,
  output logic        Co
);
  always_comb begin
    logic [23:0] g;
    logic [23:0] p;
    logic        c_blk;
    logic        c_bit;
    logic        bg;
    logic        bp;
    g     = A & B;
    p     = A ^ B;
    S     = '0;
    c_blk = Ci;
    for (int unsigned j = 0; j < 6; j++) begin
      bg    = 1'b0;
      bp    = 1'b1;
      c_bit = c_blk;
      for (int unsigned i = 0; i < 4; i++) begin
        S[4*j+i] = p[4*j+i] ^ c_bit;
        c_bit    = g[4*j+i] | (p[4*j+i] & c_bit);
        bg       = g[4*j+i] | (p[4*j+i] & bg);
        bp       = bp & p[4*j+i];
      end
      // Block carry comes from the group generate/propagate terms.
      c_blk = bg | (bp & c_blk);
    end
    Co = c_blk;
  end
endmodule

module fp_add_seq #(
  parameter int unsigned ALIGN_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  localparam logic [4:0] STEP5 = 5'(ALIGN_STEP);

  state_t      r_state, w_state_nxt;
  logic        r_sx, w_sx_nxt;
  logic [7:0]  r_ex, w_ex_nxt;
  logic [23:0] r_mx, w_mx_nxt;
  logic [23:0] r_my, w_my_nxt;
  logic [4:0]  r_d, w_d_nxt;
  logic        r_esub, w_esub_nxt;
  logic [24:0] r_sum, w_sum_nxt;
  logic [31:0] r_result, w_result_nxt;
  logic [2:0]  r_flags, w_flags_nxt;

  // Operand unpacking at accept
  logic        w_sa, w_sb, w_sx, w_sy, w_a_ge;
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [4:0]  w_sh;

  logic [23:0] w_cla_b, w_cla_s;
  logic        w_cla_co;

  assign w_sa     = a[31];
  assign w_sb     = b[31] ^ sub;
  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_a_nan  = (w_ea == 8'hFF) && (a[22:0] != '0);
  assign w_b_nan  = (w_eb == 8'hFF) && (b[22:0] != '0);
  assign w_a_inf  = (w_ea == 8'hFF) && (a[22:0] == '0);
  assign w_b_inf  = (w_eb == 8'hFF) && (b[22:0] == '0);
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_ge   = (a[30:0] >= b[30:0]);
  assign w_sx     = w_a_ge ? w_sa : w_sb;
  assign w_sy     = w_a_ge ? w_sb : w_sa;
  assign w_ex     = w_a_ge ? w_ea : w_eb;
  assign w_ey     = w_a_ge ? w_eb : w_ea;
  assign w_mx     = {1'b1, (w_a_ge ? a[22:0] : b[22:0])};
  assign w_my     = {1'b1, (w_a_ge ? b[22:0] : a[22:0])};
  assign w_d      = w_ex - w_ey;
  assign w_sh     = (r_d < STEP5) ? r_d : STEP5;

  // Subtraction as mx + ~my + 1; mx >= my so the carry out is meaningless.
  assign w_cla_b = r_esub ? ~r_my : r_my;

  CLA24bit u_cla (
    .A  (r_mx),
    .B  (w_cla_b),
    .Ci (r_esub),
    .S  (w_cla_s),
    .Co (w_cla_co)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sx     <= 1'b0;
      r_ex     <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_d      <= '0;
      r_esub   <= 1'b0;
      r_sum    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sx     <= w_sx_nxt;
      r_ex     <= w_ex_nxt;
      r_mx     <= w_mx_nxt;
      r_my     <= w_my_nxt;
      r_d      <= w_d_nxt;
      r_esub   <= w_esub_nxt;
      r_sum    <= w_sum_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sx_nxt     = r_sx;
    w_ex_nxt     = r_ex;
    w_mx_nxt     = r_mx;
    w_my_nxt     = r_my;
    w_d_nxt      = r_d;
    w_esub_nxt   = r_esub;
    w_sum_nxt    = r_sum;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_flags_nxt = '0;
          w_state_nxt = S_DONE;
          if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_result_nxt = 32'h7FC0_0000;
            w_flags_nxt  = 3'b100;
          end else if (w_a_inf) begin
            w_result_nxt = {w_sa, 8'hFF, 23'h0};
          end else if (w_b_inf) begin
            w_result_nxt = {w_sb, 8'hFF, 23'h0};
          end else if (w_a_zero && w_b_zero) begin
            w_result_nxt = {w_sa & w_sb, 31'h0};
          end else if (w_a_zero) begin
            w_result_nxt = {w_sb, b[30:0]};
          end else if (w_b_zero) begin
            w_result_nxt = {w_sa, a[30:0]};
          end else begin
            w_sx_nxt   = w_sx;
            w_ex_nxt   = w_ex;
            w_mx_nxt   = w_mx;
            w_esub_nxt = (w_sx != w_sy);
            w_my_nxt   = w_my;
            w_d_nxt    = '0;
            if (w_d == '0) begin
              w_state_nxt = S_ADD;
            end else if (w_d > 8'd24) begin
              w_my_nxt    = '0;
              w_state_nxt = S_ADD;
            end else begin
              w_d_nxt     = w_d[4:0];
              w_state_nxt = S_ALIGN;
            end
          end
        end
      end
      S_ALIGN: begin
        w_my_nxt = r_my >> w_sh;
        w_d_nxt  = r_d - w_sh;
        if (w_d_nxt == '0) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        w_sum_nxt = {w_cla_co & ~r_esub, w_cla_s};
        if (r_esub && (w_cla_s == '0)) begin
          w_result_nxt = '0;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_sum[24]) begin
          w_state_nxt = S_DONE;
          if (r_ex == 8'd254) begin
            w_result_nxt = {r_sx, 8'hFF, 23'h0};
            w_flags_nxt  = 3'b010;
          end else begin
            w_result_nxt = {r_sx, r_ex + 8'd1, r_sum[23:1]};
          end
        end else if (r_sum[23]) begin
          w_result_nxt = {r_sx, r_ex, r_sum[22:0]};
          w_state_nxt  = S_DONE;
        end else if (r_ex == 8'd1) begin
          w_result_nxt = {r_sx, 31'h0};
          w_flags_nxt  = 3'b001;
          w_state_nxt  = S_DONE;
        end else begin
          w_sum_nxt = {r_sum[23:0], 1'b0};
          w_ex_nxt  = r_ex - 8'd1;
          // Look one bit ahead so the final shift also packs the result,
          // saving the extra NORM cycle after the hidden bit lands.
          if (r_sum[22]) begin
            w_result_nxt = {r_sx, r_ex - 8'd1, r_sum[21:0], 1'b0};
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_add_seq.sv
module tb_fp_add_seq;
  localparam int unsigned STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_seq #(.ALIGN_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  vec_t tv[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the unpacked fields, truncating
  // the aligned operand, then normalising until the hidden bit is in place.
  function automatic void ref_add(input logic [31:0] fa, input logic [31:0] fb,
                                  input logic fsub, output logic [31:0] res,
                                  output logic [2:0] fl, output int lat);
    logic sa, sb, sx, sy;
    int ea, eb, ex, ey, d, align, e, k;
    longint mx, my, m;
    bit anan, bnan, ainf, binf;
    sa = fa[31];
    sb = fb[31] ^ fsub;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    anan = (ea == 255) && (fa[22:0] != 0);
    bnan = (eb == 255) && (fb[22:0] != 0);
    ainf = (ea == 255) && (fa[22:0] == 0);
    binf = (eb == 255) && (fb[22:0] == 0);
    fl = 3'b000;
    lat = 1;
    res = 32'h0;
    if (anan || bnan || (ainf && binf && sa != sb)) begin
      res = 32'h7FC00000; fl = 3'b100; return;
    end
    if (ainf) begin res = {sa, 8'hFF, 23'h0}; return; end
    if (binf) begin res = {sb, 8'hFF, 23'h0}; return; end
    if (ea == 0 && eb == 0) begin res = {sa & sb, 31'h0}; return; end
    if (ea == 0) begin res = {sb, fb[30:0]}; return; end
    if (eb == 0) begin res = {sa, fa[30:0]}; return; end
    if (fa[30:0] >= fb[30:0]) begin
      ex = ea; ey = eb; sx = sa; sy = sb;
      mx = 64'd8388608 + longint'(fa[22:0]);
      my = 64'd8388608 + longint'(fb[22:0]);
    end else begin
      ex = eb; ey = ea; sx = sb; sy = sa;
      mx = 64'd8388608 + longint'(fb[22:0]);
      my = 64'd8388608 + longint'(fa[22:0]);
    end
    d = ex - ey;
    align = (d == 0 || d > 24) ? 0 : (d + int'(STEP) - 1) / int'(STEP);
    my = (d > 24) ? 0 : (my >> d);
    m = (sx != sy) ? mx - my : mx + my;
    if (m == 0) begin res = 32'h0; lat = 2 + align; return; end
    e = ex;
    if (m >= 64'd16777216) begin
      e = e + 1;
      lat = 3 + align;
      if (e >= 255) begin res = {sx, 8'hFF, 23'h0}; fl = 3'b010; end
      else res = {sx, 8'(e), 23'(m >> 1)};
      return;
    end
    k = 0;
    while (m < 64'd8388608) begin
      m = m * 2;
      e = e - 1;
      k = k + 1;
      if (e == 0) begin
        res = {sx, 31'h0}; fl = 3'b001; lat = 2 + align + k; return;
      end
    end
    res = {sx, 8'(e), 23'(m)};
    lat = 2 + align + ((k > 1) ? k : 1);
  endfunction

  // One full transaction; latency counts the accept edge as edge 1.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       output logic [31:0] res, output logic [2:0] fl, output int lat,
                       output bit ok);
    int w;
    ok = 1'b0;
    res = '0;
    fl = '0;
    lat = 0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
      return;
    end
    res = result;
    fl = flags;
    ok = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic run_check(input string name, input logic [31:0] ia, input logic [31:0] ib,
                           input logic isub, input logic [31:0] er, input logic [2:0] ef,
                           input int el);
    logic [31:0] r;
    logic [2:0] f;
    int l;
    bit ok;
    do_op(ia, ib, isub, r, f, l, ok);
    if (ok) begin
      check({name, "_result"}, r, er);
      check({name, "_flags"}, {29'h0, f}, {29'h0, ef});
      check({name, "_latency"}, 32'(l), 32'(el));
    end
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic [2:0] ef;
    logic rs;
    int el, tmp, ea, mode, w;

    tv[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 3};
    tv[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 4};
    tv[2]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000, 27};
    tv[3]  = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 25};
    tv[4]  = '{32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3'b000, 2};
    tv[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, 3};
    tv[6]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 3};
    tv[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1};
    tv[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 1};
    tv[9]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 1};
    tv[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 1};
    tv[11] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 1};
    tv[12] = '{32'h7FC00001, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100, 1};
    tv[13] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000, 3};
    tv[14] = '{32'h4C000000, 32'h3F800000, 1'b0, 32'h4C000000, 3'b000, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_result", result, 32'h0);
    check("reset_flags", {29'h0, flags}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run_check($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].sub, tv[i].res, tv[i].fl, tv[i].lat);

    // Output stall: result held while the consumer is not ready; new
    // requests during the stall are ignored.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    check("stall_reached_valid", {31'h0, out_valid}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = 32'h7F800000; b = 32'hFF800000; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stall%0d_out_valid", c), {31'h0, out_valid}, 32'h1);
      check($sformatf("stall%0d_result", c), result, 32'h40000000);
      check($sformatf("stall%0d_flags", c), {29'h0, flags}, 32'h0);
      check($sformatf("stall%0d_in_ready", c), {31'h0, in_ready}, 32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_out_valid", {31'h0, out_valid}, 32'h0);
    check("stall_release_in_ready", {31'h0, in_ready}, 32'h1);

    // Reset while aligning discards the operation.
    @(negedge clk);
    a = 32'h4B800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
    check("midreset_in_ready", {31'h0, in_ready}, 32'h1);
    check("midreset_result", result, 32'h0);
    check("midreset_flags", {29'h0, flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midreset_no_stale_output", {31'h0, out_valid}, 32'h0);
    run_check("after_reset", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 4);

    // Randomized operands against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      if (mode != 0) begin
        ea = int'($urandom_range(1, 254));
        ra[30:23] = 8'(ea);
        tmp = ea - int'($urandom_range(0, 30));
        if (tmp < 1) tmp = 1;
        rb[30:23] = 8'(tmp);
      end
      if (mode == 3) begin
        rb = ra ^ 32'($urandom_range(0, 255));
        rb[31] = ra[31];
        rs = 1'b1;
      end
      ref_add(ra, rb, rs, er, ef, el);
      run_check($sformatf("rand%0d", i), ra, rb, rs, er, ef, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Multi-cycle FP32 add/subtract sequencer built around one CLA24bit mantissa adder (ports A, B, Ci, S, Co).
- Unpacks the operands, swaps and aligns them, drives the CLA for one cycle, then normalizes iteratively and packs the result.
- valid/ready handshake on input and output; one operation in flight.
- Rounding is truncation (shifted-out bits discarded); denormals are flushed to zero.

Parameters:
ALIGN_STEP, 1, bits the smaller mantissa is right-shifted per ALIGN cycle; legal values 1, 2, 4, 8.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  high when state==IDLE (combinational from state)
a  in  32  operand A, IEEE-754 single
b  in  32  operand B, IEEE-754 single
sub  in  1  1 = a-b, 0 = a+b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  packed FP32 result
flags  out  3  {invalid, overflow, underflow}; valid with out_valid

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0; result=0; flags=0.
  - Any in-flight operation is discarded and produces no output.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE, accept when in_valid && in_ready:
  - Effective sign of b: sb = b[31]^sub.
  - x = operand with larger {exp,mant}; y = the other; d = ex-ey.
  - Effective subtract when sx != sy.
  - Mantissas get hidden bit 1 (24 bits).
- Special cases at accept go straight to DONE (out_valid one edge after accept):
  - Any NaN, or inf with opposite effective-sign inf: result=7FC00000, invalid=1.
  - Any inf otherwise: signed inf.
  - exp==0 operands are treated as zero.
  - Both zero: -0 only if both effective signs negative, else +0.
  - One zero: result = other operand with its effective sign.
- ALIGN:
  - Shift my right by min(ALIGN_STEP, remaining d) per cycle.
  - If d>24, my=0 and ALIGN is skipped.
  - d==0 skips ALIGN.
- ADD (one cycle):
  - Add: CLA A=mx, B=my, Ci=0; register {Co,S}.
  - Subtract: B=~my, Ci=1; Co is ignored since mx>=my.
  - Zero difference: result=+0, go to DONE.
- NORM:
  - Add with carry: shift right 1, exp+1, go to DONE. exp reaching 255 gives signed inf, overflow=1.
  - Else if S[23]==1: go to DONE.
  - Else shift left 1, exp-1, stay in NORM. exp reaching 0 gives signed zero (sign of x), underflow=1.
- Result sign = sx.
- Latency, accept edge to out_valid rising: 2 + ceil(min(d,24 or skipped)/ALIGN_STEP) + max(1,k) edges, where k = number of NORM shifts.
- DONE:
  - out_valid=1 while result/flags are held stable.
  - On out_valid && out_ready: go to IDLE; out_valid drops next edge.
  - New input is not accepted in the same cycle as output handoff.
- in_valid while busy is ignored; the source must hold it until in_ready.

Test Plan:
- ALIGN_STEP=1; a=3F800000, b=3F800000, sub=0 -> result=40000000, flags=0, out_valid rises 3 edges after accept.
- a=40400000, b=3F800000, sub=1 -> 40000000, out_valid 4 edges after accept. Also a=4B800000, b=3F800000, sub=0 (d=24) -> 4B800000.
- Cancellation: a=3F800001, b=3F800000, sub=1 -> 34000000 after 23 NORM shifts (out_valid at edge 25); a=b=40490FDB, sub=1 -> 00000000.
- Overflow: a=b=7F7FFFFF, sub=0 -> 7F800000, overflow=1. Underflow: a=00800001, b=00800000, sub=1 -> 00000000, underflow=1.
- Specials: a=7F800000, b=FF800000, sub=0 -> 7FC00000, invalid=1, one edge latency. a=FF800000, b=3F800000 -> FF800000, flags=0.
- Handshake/reset:
  - out_ready=0 for 5 cycles: out_valid, result and flags stable; in_ready=0.
  - rst_n pulled low during ALIGN: out_valid=0 immediately; in_ready=1 after release; next op correct.
